// File: rtl/mac_pkg.sv
// Shared constants and types for the MAC feeder / MAC array pair.
package mac_pkg;

  localparam int BW      = 4;
  localparam int PSUM_BW = 16;
  localparam int COL     = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } feeder_state_t;

  typedef logic [COL-1:0][BW-1:0] lane_vec_t;

endpackage

// File: rtl/mac_array.sv
// 4-lane MAC: psum_out <= psum_in + sum(x[i] * w[i]), x unsigned, w signed.
// Registered output, one cycle of latency, wraps silently on overflow.
module mac_array
  import mac_pkg::*;
#(
  parameter int bw      = BW,
  parameter int psum_bw = PSUM_BW,
  parameter int col     = COL
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [col*bw-1:0]         x,
  input  logic [col*bw-1:0]         w,
  input  logic signed [psum_bw-1:0] psum_in,
  output logic signed [psum_bw-1:0] psum_out
);

  logic signed [psum_bw-1:0] dot;

  // Unsigned activation times signed weight, extended to the psum width.
  function automatic logic signed [psum_bw-1:0] lane_prod(input logic [bw-1:0] a,
                                                          input logic signed [bw-1:0] b);
    logic signed [bw:0]        a_s;
    logic signed [psum_bw-1:0] p;
    a_s = {1'b0, a};
    p   = psum_bw'(a_s) * psum_bw'(b);
    return p;
  endfunction

  // Sum of lane products for the vector currently on the inputs.
  always_comb begin
    dot = '0;
    for (int i = 0; i < col; i++) begin
      dot = dot + lane_prod(x[i*bw +: bw], w[i*bw +: bw]);
    end
  end

  // Output register: accumulate onto the incoming partial sum.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) psum_out <= '0;
    else          psum_out <= psum_in + dot;
  end

endmodule

// File: rtl/mac_feeder.sv
// Sequencer in front of mac_array: takes packed x/w vectors over valid/ready,
// issues one per cycle, closes the psum feedback loop and returns the final sum.
module mac_feeder
  import mac_pkg::*;
#(
  parameter int bw      = BW,
  parameter int psum_bw = PSUM_BW,
  parameter int col     = COL,
  parameter int len_bw  = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [len_bw-1:0]         len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [col*bw-1:0]         x_in,
  input  logic [col*bw-1:0]         w_in,
  output logic [col*bw-1:0]         x,
  output logic [col*bw-1:0]         w,
  output logic signed [psum_bw-1:0] psum_in,
  input  logic signed [psum_bw-1:0] psum_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [psum_bw-1:0] out_data,
  output logic                      busy
);

  feeder_state_t             state;
  logic [len_bw-1:0]         len_q;
  logic [len_bw-1:0]         count;
  logic signed [psum_bw-1:0] acc;
  logic                      vld_p0;    // x/w currently hold an issued vector
  logic                      issued_q;  // psum_out currently holds a result we issued
  logic                      accept;

  // Once the last vector is in, stop accepting; the following cycle moves to DRAIN.
  assign in_ready = (state == RUN) && (count != len_q);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  // Feed back the fresh result when there is one, else the sum held across bubbles.
  assign psum_in  = issued_q ? psum_out : acc;

  // Control FSM: vector counting, drain timing and the result handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      len_q     <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q <= len;
            count <= '0;
            if (len == '0) begin
              out_data  <= '0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (count == len_q) state <= DRAIN;
          else if (accept)    count <= count + len_bw'(1);
        end
        DRAIN: begin
          out_data  <= psum_out;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p0: vector issue register plus the feedback-loop bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x        <= '0;
      w        <= '0;
      vld_p0   <= 1'b0;
      issued_q <= 1'b0;
      acc      <= '0;
    end else begin
      x        <= accept ? x_in : '0;
      w        <= accept ? w_in : '0;
      vld_p0   <= accept;
      issued_q <= vld_p0;
      if (state == IDLE && start) acc <= '0;
      else if (issued_q)          acc <= psum_out;
    end
  end

endmodule

// File: tb/tb_mac_feeder.sv
// Directed bench for mac_feeder driving the mac_array model.
module tb_mac_feeder;
  import mac_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x_in, w_in, x, w;
  logic [15:0] psum_in, psum_out;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_feeder dut (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .w_in(w_in),
    .x(x), .w(w), .psum_in(psum_in), .psum_out(psum_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  mac_array u_mac (
    .clk(clk), .reset_n(reset_n), .x(x), .w(w),
    .psum_in(psum_in), .psum_out(psum_out)
  );

  typedef struct {
    logic [15:0] xv;
    logic [15:0] wv;
    logic [7:0]  n;
    logic [15:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Start a job with in_valid held high, wait for the result and take it.
  task automatic run_job(input logic [15:0] xv, input logic [15:0] wv, input logic [7:0] n,
                         output logic [15:0] res, output int lat);
    @(posedge clk); #1;
    start = 1'b1; len = n; x_in = xv; w_in = wv; in_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!out_valid && lat < 1000) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) check("job_timeout", 32'(out_valid), 32'd1);
    in_valid  = 1'b0;
    res       = out_data;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic wait_result(input int budget);
    int c;
    c = 0;
    while (!out_valid && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    if (!out_valid) check("wait_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_x"},         32'(x),         32'h0);
    check({tag, "_w"},         32'(w),         32'h0);
    check({tag, "_psum_in"},   32'(psum_in),   32'h0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    check({tag, "_out_data"},  32'(out_data),  32'h0);
    check({tag, "_in_ready"},  32'(in_ready),  32'h0);
    check({tag, "_busy"},      32'(busy),      32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] res;
    int          lat;

    tbl[0] = '{16'h1111, 16'h1111, 8'd10,  16'h0028, 12};
    tbl[1] = '{16'hFFFF, 16'h8888, 8'd3,   16'hFA60, 5};
    tbl[2] = '{16'hFFFF, 16'h7777, 8'd200, 16'h4820, 202};
    tbl[3] = '{16'h2222, 16'h3333, 8'd1,   16'h0018, 3};

    reset_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
    x_in = '0; w_in = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Table of uninterrupted jobs.
    for (int i = 0; i < 4; i++) begin
      run_job(tbl[i].xv, tbl[i].wv, tbl[i].n, res, lat);
      check($sformatf("tbl%0d_data", i), 32'(res), 32'(tbl[i].exp_data));
      check($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
      check($sformatf("tbl%0d_valid_clr", i), 32'(out_valid), 32'd0);
      check($sformatf("tbl%0d_idle", i), 32'(busy), 32'd0);
    end

    // Bubble: in_valid 1,0,0,1 with len=2.
    @(posedge clk); #1;
    start = 1'b1; len = 8'd2; x_in = 16'h2222; w_in = 16'h3333; in_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("bub_psum_first", 32'(psum_in), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bub_ready_gap", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("bub_psum_fb", 32'(psum_in), 32'd24);
    @(posedge clk); #1;
    check("bub_psum_acc", 32'(psum_in), 32'd24);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bub_ready_after_last", 32'(in_ready), 32'd0);
    check("bub_busy", 32'(busy), 32'd1);
    wait_result(20);
    check("bub_data", 32'(out_data), 32'h0030);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bub_valid_clr", 32'(out_valid), 32'd0);

    // len=0 goes straight to DONE; result held under back-pressure; start ignored.
    @(posedge clk); #1;
    start = 1'b1; len = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    check("len0_valid", 32'(out_valid), 32'd1);
    check("len0_data", 32'(out_data), 32'd0);
    check("len0_busy", 32'(busy), 32'd1);
    check("len0_ready", 32'(in_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      start = (k == 2);
      len   = (k == 2) ? 8'd7 : 8'd0;
      @(posedge clk); #1;
      check($sformatf("hold%0d_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("hold%0d_data", k), 32'(out_data), 32'd0);
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("len0_valid_clr", 32'(out_valid), 32'd0);
    check("len0_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("len0_no_restart", 32'(busy), 32'd0);

    // Abort mid-run with asynchronous reset after 3 of 10 vectors.
    @(posedge clk); #1;
    start = 1'b1; len = 8'd10; x_in = 16'h1111; w_in = 16'h1111; in_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("abort_busy_before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check_all_zero("abort");
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Fresh run with out_ready already high on the first DONE cycle.
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; len = 8'd1; x_in = 16'h1111; w_in = 16'hFFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check("post_abort_valid", 32'(out_valid), 32'd1);
    check("post_abort_data", 32'(out_data), 32'hFFFC);
    check("post_abort_lat", 32'(lat), 32'd3);
    @(posedge clk); #1;
    check("post_abort_valid_clr", 32'(out_valid), 32'd0);
    check("post_abort_idle", 32'(busy), 32'd0);
    out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
